// File: rtl/word_matcher_pkg.sv
// -----------------------------------------------------------------------------
// word_matcher_pkg
// Shared constants, the character type and a byte-slicing helper for the
// word_matcher streaming pattern-match engine.
//   CHAR_W      : width of one text character
//   MAX_WORD    : longest programmable word (one byte lane per character)
//   MAX_RESULTS : results reported per text before the engine goes quiet
// -----------------------------------------------------------------------------
package word_matcher_pkg;

    localparam int CHAR_W      = 8;
    localparam int MAX_WORD    = 8;
    localparam int MAX_RESULTS = 8;

    typedef logic [CHAR_W-1:0] char_t;

    // Byte i of a packed MAX_WORD-character register (i = 0 is the lowest byte).
    function automatic char_t lane_char(input logic [MAX_WORD*CHAR_W-1:0] vec,
                                        input int i);
        return vec[i*CHAR_W +: CHAR_W];
    endfunction

endpackage

// File: rtl/char_lane_cmp.sv
// -----------------------------------------------------------------------------
// char_lane_cmp
// Masked compare of one text character against one word character.
//   ch      in  : candidate text character
//   pattern in  : programmed word character
//   mask    in  : 1 bits are compared, 0 bits are don't-care
//   match   out : 1 when every masked bit agrees
// -----------------------------------------------------------------------------
module char_lane_cmp
    import word_matcher_pkg::*;
(
    input  char_t ch,
    input  char_t pattern,
    input  char_t mask,
    output logic  match
);

    assign match = ((ch ^ pattern) & mask) == '0;

endmodule

// File: rtl/word_matcher.sv
// -----------------------------------------------------------------------------
// word_matcher
// Streaming matcher: slides a window over the incoming character stream and
// reports the start index of every occurrence of the programmed word, one
// result per input beat, one cycle after the beat.
//
// Ports
//   sclk, rst_n          : clock, synchronous active-low reset
//   aresetn              : engine enable; low clears counters and drops output
//   word_size [7:0]      : word length L (only 1..MAX_WORD can ever match)
//   result_mask [7:0]    : ANDed onto every emitted result id
//   characters [63:0]    : byte i = word character i
//   masks [63:0]         : byte i = compare mask of word character i
//   s_axis_tvalid/tdata/tuser : text beat in, tuser = end-of-text
//   m_axis_tvalid/tdata  : result beat out
//   result_count [3:0]   : results emitted for the current text (saturating)
//
// Build option
//   WORD_MATCHER_OVERLAP_EN : when defined, overlapping occurrences are all
//   reported; otherwise a hit suppresses the next L-1 characters so matches
//   are non-overlapping, leftmost first.
// -----------------------------------------------------------------------------
module word_matcher #(
    parameter int MAX_WORD    = 8,
    parameter int MAX_RESULTS = 8
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic                  aresetn,
    input  logic [7:0]            word_size,
    input  logic [7:0]            result_mask,
    input  logic [8*MAX_WORD-1:0] characters,
    input  logic [8*MAX_WORD-1:0] masks,
    input  logic                  s_axis_tvalid,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tuser,
    output logic                  m_axis_tvalid,
    output logic [7:0]            m_axis_tdata,
    output logic [3:0]            result_count
);

    import word_matcher_pkg::*;

    localparam int IDX_W = $clog2(MAX_WORD);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    // Only the newest MAX_WORD-1 characters are kept: the candidate window
    // always includes the incoming character, so the oldest slot is never read.
    char_t            win_reg [MAX_WORD-1];
    logic [3:0]       fill_reg,  fill_next;
    logic [7:0]       pos_reg,   pos_next;
    logic [2:0]       skip_reg,  skip_next;
    logic [3:0]       count_reg, count_next;
    logic             valid_reg, valid_next;
    logic [7:0]       data_reg,  data_next;

    // ---------------------------------------------------------------------
    // Candidate window and per-lane compare
    // ---------------------------------------------------------------------
    char_t            cand [MAX_WORD];
    logic [IDX_W-1:0] last_idx;
    logic [MAX_WORD-1:0] lane_ok;

    logic data_beat;
    logic end_beat;
    logic len_ok, fill_ok, pos_ok, skip_ok, count_ok;
    logic hit;
    logic [7:0] result_id;

    assign data_beat = s_axis_tvalid && !s_axis_tuser;
    assign end_beat  = s_axis_tvalid &&  s_axis_tuser;

    // cand[0] is the character arriving now, cand[j] the one j beats ago.
    assign cand[0] = s_axis_tdata;

    genvar gi;
    generate
        for (gi = 1; gi < MAX_WORD; gi++) begin : g_cand
            assign cand[gi] = win_reg[gi-1];
        end
    endgenerate

    // Word character i lines up with cand[L-1-i]; only meaningful for
    // 1 <= L <= MAX_WORD, which len_ok enforces separately.
    assign last_idx = IDX_W'(word_size - 8'd1);

    generate
        for (gi = 0; gi < MAX_WORD; gi++) begin : g_lane
            logic [IDX_W-1:0] idx;
            char_t            sel;
            logic             eq;

            assign idx = last_idx - IDX_W'(gi);
            assign sel = cand[idx];

            char_lane_cmp u_cmp (
                .ch      (sel),
                .pattern (lane_char(characters, gi)),
                .mask    (lane_char(masks, gi)),
                .match   (eq)
            );

            // Lanes beyond the word length are don't-care.
            assign lane_ok[gi] = eq || (8'(gi) >= word_size);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Hit qualification
    // ---------------------------------------------------------------------
    assign len_ok   = (word_size != 8'd0) && (word_size <= 8'(MAX_WORD));
    assign fill_ok  = ({5'd0, fill_reg} + 9'd1) >= {1'b0, word_size};
    assign pos_ok   = (pos_reg != 8'hFF);
    assign skip_ok  = (skip_reg == 3'd0);
    assign count_ok = (count_reg < 4'(MAX_RESULTS));

    assign hit = data_beat && (&lane_ok) && len_ok && fill_ok &&
                 pos_ok && skip_ok && count_ok;

    // Start index of the occurrence ending at the current character.
    assign result_id = (pos_reg - word_size + 8'd1) & result_mask;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        valid_next = 1'b0;
        data_next  = data_reg;
        fill_next  = fill_reg;
        pos_next   = pos_reg;
        skip_next  = skip_reg;
        count_next = count_reg;

        if (!aresetn || end_beat) begin
            fill_next  = '0;
            pos_next   = '0;
            skip_next  = '0;
            count_next = '0;
        end else if (data_beat) begin
            if (hit) begin
                valid_next = 1'b1;
                data_next  = result_id;
                count_next = count_reg + 4'd1;
            end

            if (fill_reg != 4'(MAX_WORD)) begin
                fill_next = fill_reg + 4'd1;
            end
            if (pos_reg != 8'hFF) begin
                pos_next = pos_reg + 8'd1;
            end

`ifdef WORD_MATCHER_OVERLAP_EN
            skip_next = '0;
`else
            // A hit holds off the next L-1 characters so the following match
            // cannot share characters with this one.
            if (hit) begin
                skip_next = last_idx;
            end else if (skip_reg != 3'd0) begin
                skip_next = skip_reg - 3'd1;
            end
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            fill_reg  <= '0;
            pos_reg   <= '0;
            skip_reg  <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            data_reg  <= data_next;
            fill_reg  <= fill_next;
            pos_reg   <= pos_next;
            skip_reg  <= skip_next;
            count_reg <= count_next;
        end
    end

    // Window contents need no reset; fill decides which slots are valid.
    always_ff @(posedge sclk) begin
        if (rst_n && aresetn && data_beat) begin
            win_reg[0] <= s_axis_tdata;
            for (int j = 1; j < MAX_WORD-1; j++) begin
                win_reg[j] <= win_reg[j-1];
            end
        end
    end

    assign m_axis_tvalid = valid_reg;
    assign m_axis_tdata  = data_reg;
    assign result_count  = count_reg;

endmodule

// File: tb/tb_word_matcher.sv
// -----------------------------------------------------------------------------
// tb_word_matcher
// Self-checking bench for word_matcher. A text-level reference model pushes
// expected {cycle, id} results into a queue as beats are driven; a monitor
// records every result beat the DUT produces; each test task drains both
// queues and compares them, plus result_count and reset values.
// -----------------------------------------------------------------------------
module tb_word_matcher;

`ifdef WORD_MATCHER_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  id;
    } res_t;

    logic        sclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aresetn = 1'b1;
    logic [7:0]  word_size = 8'd0;
    logic [7:0]  result_mask = 8'hFF;
    logic [63:0] characters = '0;
    logic [63:0] masks = '0;
    logic        s_axis_tvalid = 1'b0;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tuser = 1'b0;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tdata;
    logic [3:0]  result_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    res_t exp_q[$];
    res_t got_q[$];

    // reference model state: the current text, end index of last hit, hits
    logic [7:0] hist[$];
    int         last_end = -1;
    int         n_res = 0;

    word_matcher dut (
        .sclk          (sclk),
        .rst_n         (rst_n),
        .aresetn       (aresetn),
        .word_size     (word_size),
        .result_mask   (result_mask),
        .characters    (characters),
        .masks         (masks),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .result_count  (result_count)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    always @(negedge sclk) begin
        if (m_axis_tvalid === 1'b1) got_q.push_back('{cyc: cyc, id: m_axis_tdata});
    end

    // Text-level model: searches the text seen so far directly.
    task automatic model_step(input logic v, input logic u, input logic [7:0] d,
                              input logic arn, input logic rn);
        int  n, len;
        bit  h;
        logic [7:0] wc, mk;
        if (!rn || !arn || (v && u)) begin
            hist.delete();
            last_end = -1;
            n_res = 0;
        end else if (v) begin
            hist.push_back(d);
            n   = hist.size();
            len = int'(word_size);
            h = (len >= 1) && (len <= 8) && (n >= len) && (n - 1 < 255) &&
                (n_res < 8) && (OVERLAP || (n - len > last_end));
            if (h) begin
                for (int k = 0; k < len; k++) begin
                    wc = characters[8*k +: 8];
                    mk = masks[8*k +: 8];
                    if (((hist[n-len+k] ^ wc) & mk) != 8'd0) h = 1'b0;
                end
            end
            if (h) begin
                exp_q.push_back('{cyc: cyc + 1, id: 8'(n - len) & result_mask});
                n_res++;
                last_end = n - 1;
            end
        end
    endtask

    task automatic beat(input logic v, input logic u, input logic [7:0] d,
                        input logic arn = 1'b1, input logic rn = 1'b1);
        @(negedge sclk);
        s_axis_tvalid = v;
        s_axis_tuser  = u;
        s_axis_tdata  = d;
        aresetn       = arn;
        rst_n         = rn;
        model_step(v, u, d, arn, rn);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) beat(1'b1, 1'b0, s[i]);
    endtask

    task automatic send_end();
        beat(1'b1, 1'b1, 8'h00);
    endtask

    task automatic settle();
        beat(1'b0, 1'b0, 8'h00);
        beat(1'b0, 1'b0, 8'h00);
        #1;
    endtask

    task automatic set_word(input string w, input logic [7:0] m, input logic [7:0] len,
                            input logic [7:0] rm = 8'hFF);
        characters = '0;
        masks = {8{m}};
        for (int i = 0; i < w.len() && i < 8; i++) characters[8*i +: 8] = w[i];
        word_size = len;
        result_mask = rm;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        beat(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        beat(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        @(posedge sclk); #1;
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
        n_vec++; if (m_axis_tdata !== 8'd0) begin n_err++; $display("FAIL reset_tdata got=%0d exp=0", m_axis_tdata); end
        n_vec++; if (result_count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", result_count); end
        $display("reset: tvalid=%b tdata=%0d count=%0d", m_axis_tvalid, m_axis_tdata, result_count);
        got_q.delete();
    endtask

    task automatic test_basic();
        res_t e, g;
        set_word("ab", 8'hFF, 8'd2);
        send_end(); send_str("xabab"); settle();
        n_vec++; if (result_count !== 4'd2) begin n_err++; $display("FAIL basic_count got=%0d exp=2", result_count); end
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_vec++; if (g !== e) begin n_err++; $display("FAIL basic_res got=%0d@%0d exp=%0d@%0d", g.id, g.cyc, e.id, e.cyc); end
            else $display("basic: id=%0d cyc=%0d", g.id, g.cyc);
        end
        got_q.delete();
    endtask

    task automatic test_case_insensitive();
        res_t e, g;
        set_word("AB", 8'hDF, 8'd2);
        send_end(); send_str("ab"); settle();
        n_vec++; if (result_count !== 4'd1) begin n_err++; $display("FAIL nocase_count got=%0d exp=1", result_count); end
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL nocase_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_vec++; if (g !== e) begin n_err++; $display("FAIL nocase_res got=%0d@%0d exp=%0d@%0d", g.id, g.cyc, e.id, e.cyc); end
            else $display("nocase: id=%0d cyc=%0d", g.id, g.cyc);
        end
        got_q.delete();
    endtask

    task automatic test_overlap();
        res_t e, g;
        logic [3:0] exp_cnt;
        exp_cnt = OVERLAP ? 4'd3 : 4'd2;
        set_word("aa", 8'hFF, 8'd2);
        send_end(); send_str("aaaa"); settle();
        n_vec++; if (result_count !== exp_cnt) begin n_err++; $display("FAIL overlap_count got=%0d exp=%0d", result_count, exp_cnt); end
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL overlap_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_vec++; if (g !== e) begin n_err++; $display("FAIL overlap_res got=%0d@%0d exp=%0d@%0d", g.id, g.cyc, e.id, e.cyc); end
            else $display("overlap: id=%0d cyc=%0d", g.id, g.cyc);
        end
        got_q.delete();
    endtask

    task automatic test_end_split();
        set_word("ab", 8'hFF, 8'd2);
        send_end(); send_str("a"); send_end(); send_str("b"); settle();
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL endsplit_nres got=%0d exp=0", got_q.size()); end
        n_vec++; if (result_count !== 4'd0) begin n_err++; $display("FAIL endsplit_count got=%0d exp=0", result_count); end
        $display("endsplit: results=%0d", got_q.size());
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_bad_len();
        logic [7:0] lens [2];
        lens[0] = 8'd0; lens[1] = 8'd9;
        for (int t = 0; t < 2; t++) begin
            set_word("aaaaaaaa", 8'hFF, lens[t]);
            send_end(); send_str("aaaaaaaaa"); settle();
            n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL badlen_nres L=%0d got=%0d exp=0", lens[t], got_q.size()); end
            n_vec++; if (result_count !== 4'd0) begin n_err++; $display("FAIL badlen_count L=%0d got=%0d exp=0", lens[t], result_count); end
            $display("badlen: L=%0d results=%0d", lens[t], got_q.size());
            exp_q.delete(); got_q.delete();
        end
    endtask

    task automatic test_saturate();
        res_t e, g;
        set_word("a", 8'hFF, 8'd1);
        send_end(); send_str("aaaaaaaaaa"); settle();
        n_vec++; if (result_count !== 4'd8) begin n_err++; $display("FAIL sat_count got=%0d exp=8", result_count); end
        n_vec++; if (got_q.size() != 8) begin n_err++; $display("FAIL sat_nres got=%0d exp=8", got_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_vec++; if (g !== e) begin n_err++; $display("FAIL sat_res got=%0d@%0d exp=%0d@%0d", g.id, g.cyc, e.id, e.cyc); end
            else $display("sat: id=%0d cyc=%0d", g.id, g.cyc);
        end
        got_q.delete();
    endtask

    task automatic test_result_mask();
        res_t e, g;
        set_word("a", 8'hFF, 8'd1, 8'h03);
        send_end(); send_str("aaaaa"); settle();
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rmask_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_vec++; if (g !== e) begin n_err++; $display("FAIL rmask_res got=%0d@%0d exp=%0d@%0d", g.id, g.cyc, e.id, e.cyc); end
            else $display("rmask: id=%0d cyc=%0d", g.id, g.cyc);
        end
        got_q.delete();
        result_mask = 8'hFF;
    endtask

    task automatic test_aresetn();
        res_t e, g;
        set_word("abc", 8'hFF, 8'd3);
        send_end(); send_str("ab");
        beat(1'b1, 1'b0, "c", 1'b0);   // ignored while disabled
        send_str("c"); settle();
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL aresetn_nres got=%0d exp=0", got_q.size()); end
        $display("aresetn: results after clear=%0d", got_q.size());
        got_q.delete(); exp_q.delete();
        // pos restarted at 0: the next "abc" starts at index 1 ("c" was index 0)
        send_str("abc"); settle();
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL aresetn_nres2 got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_vec++; if (g !== e) begin n_err++; $display("FAIL aresetn_res got=%0d@%0d exp=%0d@%0d", g.id, g.cyc, e.id, e.cyc); end
            else $display("aresetn: id=%0d cyc=%0d", g.id, g.cyc);
        end
        got_q.delete();
    endtask

    task automatic test_rst_mid();
        res_t e, g;
        set_word("a", 8'hFF, 8'd1);
        send_end(); send_str("a");
        beat(1'b1, 1'b0, "a", 1'b1, 1'b0);
        @(posedge sclk); #1;
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got=%b exp=0", m_axis_tvalid); end
        n_vec++; if (result_count !== 4'd0) begin n_err++; $display("FAIL rstmid_count got=%0d exp=0", result_count); end
        settle();
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_vec++; if (g !== e) begin n_err++; $display("FAIL rstmid_res got=%0d@%0d exp=%0d@%0d", g.id, g.cyc, e.id, e.cyc); end
            else $display("rstmid: id=%0d cyc=%0d", g.id, g.cyc);
        end
        got_q.delete();
    endtask

    task automatic test_pos_sat();
        res_t e, g;
        set_word("a", 8'hFF, 8'd1);
        send_end();
        for (int i = 0; i < 254; i++) beat(1'b1, 1'b0, "x");
        send_str("aaa"); settle();   // indices 254, 255, 256
        n_vec++; if (result_count !== 4'd1) begin n_err++; $display("FAIL possat_count got=%0d exp=1", result_count); end
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL possat_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_vec++; if (g !== e) begin n_err++; $display("FAIL possat_res got=%0d@%0d exp=%0d@%0d", g.id, g.cyc, e.id, e.cyc); end
            else $display("possat: id=%0d cyc=%0d", g.id, g.cyc);
        end
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        res_t e, g;
        set_word("a", 8'hFF, 8'd1);
        send_end(); send_str("aaa"); send_end(); settle();
        n_vec++; if (result_count !== 4'd0) begin n_err++; $display("FAIL b2b_count got=%0d exp=0", result_count); end
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_vec++; if (g !== e) begin n_err++; $display("FAIL b2b_res got=%0d@%0d exp=%0d@%0d", g.id, g.cyc, e.id, e.cyc); end
            else $display("b2b: id=%0d cyc=%0d", g.id, g.cyc);
        end
        got_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_case_insensitive();
        test_overlap();
        test_end_split();
        test_bad_len();
        test_saturate();
        test_result_mask();
        test_aresetn();
        test_rst_mid();
        test_pos_sat();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
